buf_cmd_writer: RTL and testbench
=================================

// Module: buf_cmd_writer
// PURPOSE
//   Host-side encoder and pusher for the 40-bit command buffer stream. It turns
//   register-style host writes into command words {op[1:0], code[5:0], data[31:0]}
//   and pushes them into the command FIFO that feeds the buffer executor.
//   A small skid queue absorbs FIFO backpressure. The block tracks stream
//   open/close around the DONE command and keeps push statistics and error flags.
// PARAMETERS
//   QDEPTH   2    skid queue entries; power of two, >=2
//   CNT_W    32   width of words_pushed counter
// PORTS
//   clk            in   1      clock
//   rst            in   1      reset, synchronous, active-high
//   host_addr      in   7      [6]=0 WRITE_REG (reg=[5:0]); [6]=1 MISC (code=[5:0])
//   host_data      in   32     command payload -> word[31:0]
//   host_stb       in   1      one-cycle write strobe
//   host_busy      out  1      registered; 1 = queue full, the next strobe is dropped
//   clear          in   1      sync pulse: clears words_pushed, overflow, bad_cmd
//   fifo_full      in   1      command FIFO cannot accept a word this cycle
//   fifo_write     out  1      combinatorial push strobe
//   fifo_wdata     out  40     combinatorial; queue head word
//   stream_active  out  1      a stream is open (first word accepted, DONE not yet pushed)
//   done_pushed    out  1      registered 1-cycle pulse after the DONE word enters the FIFO
//   overflow       out  1      sticky: strobe dropped because the queue was full
//   bad_cmd        out  1      sticky: rejected code (BUF_CMD_WRITER_CHECK_EN only)
//   queue_level    out  $clog2(QDEPTH)+1  entries held in the queue
//   words_pushed   out  CNT_W  words written to the FIFO; saturates at all-ones
// BEHAVIOUR
//   Encoding: word = host_addr[6] ? {2'b10, host_addr[5:0], data}
//                                 : {2'b01, host_addr[5:0], data}
//   Accept: host_stb && level<QDEPTH; the word is written at queue tail. Uses the
//     current level, so a pop in the same cycle does not open a slot.
//   Drop: host_stb && level==QDEPTH -> word discarded, overflow<=1.
//   Pop: fifo_write = (level!=0) && !fifo_full; fifo_wdata = head. Without
//     backpressure, a strobe in cycle N produces fifo_write in cycle N+1.
//   Simultaneous push and pop: level unchanged; the order of words is preserved.
//   host_busy <= (next_level==QDEPTH).
//   words_pushed: +1 per fifo_write; holds at 2^CNT_W-1.
//   Stream FSM (registered):
//     S_IDLE    - on accept -> S_STREAM; if the accepted word is DONE, -> S_CLOSING directly
//     S_STREAM  - on accept of DONE (word[39:32]==8'hBF) -> S_CLOSING
//     S_CLOSING - on fifo_write of the DONE word -> S_IDLE, done_pushed<=1
//     stream_active = (state!=S_IDLE).
//   Words after DONE are accepted and queued normally in S_CLOSING; they open
//     the next stream once the DONE word pops.
//   clear: affects counters and flags only. The queue and the FSM are untouched.
//     clear and an event in the same cycle: the event wins (flag=1, count=1).
//   Reset values: level=0, host_busy=0, fifo_write=0, fifo_wdata=0,
//     stream_active=0, done_pushed=0, overflow=0, bad_cmd=0,
//     words_pushed=0, state=S_IDLE.
//   Reset mid-operation: queued words are lost. No partial FIFO write occurs,
//     because fifo_write is gated by level!=0.
// CONFIGURATION
//   `BUF_CMD_WRITER_CHECK_EN defined: MISC codes outside {0..15, 63} are
//     rejected at accept time. The word is not queued and bad_cmd<=1. The
//     strobe still counts as consumed, so it cannot also set overflow.
//   Macro undefined: all 64 MISC codes pass through unchecked; bad_cmd is tied 0.
// STRUCTURE
//   Shared package buf_cmd_pkg: OP_WRITE_REG=2'b01, OP_MISC=2'b10;
//     MISC codes NOP=0, STB=1, WAIT_ALL=2, WAIT_ANY=3, CLEAR=4, WAIT_FIFO=5,
//     PARAM_ADDR=6, PARAM_WRITE_HI=7, PARAM_WRITE_LO=8..14,
//     PARAM_WRITE_LO_NC=15, DONE=63; CMD_W=40.
//   One sub-module: buf_cmd_skidq. It is a QDEPTH x 40 circular queue with a
//     push/pop/level interface. This module adds the encoder, FSM, counters
//     and flags.
// TESTING
//   1. addr=0x05, data=0x1234 with FIFO ready -> fifo_write in cycle N+1,
//      wdata=40'h45_00001234, words_pushed=1, stream_active=1.
//   2. fifo_full=1, three strobes -> first two queued, host_busy=1, third dropped
//      with overflow=1. Release fifo_full -> exactly 2 words, in order.
//   3. Push MISC 63 (addr=0x7F) -> wdata=40'hBF_xxxxxxxx, done_pushed pulses
//      1 cycle after the pop, stream_active=0.
//   4. Strobe and pop in the same cycle at level=QDEPTH -> strobe dropped,
//      overflow=1, level goes to QDEPTH-1.
//   5. CHECK_EN, addr=0x50 (code 16) -> no fifo_write, bad_cmd=1. Without the
//      macro, the word 40'h90_... is pushed.
//   6. rst with 2 words queued and fifo_full=1 -> level=0; no write after release.

Source files
------------

// File: rtl/buf_cmd_pkg.sv
// ---------------------------------------------------------------------------
// buf_cmd_pkg
// Shared definitions for the command buffer stream.
//   - Command word layout: {op[1:0], code[5:0], data[31:0]}, CMD_W bits wide.
//   - Opcodes and MISC command codes used by the host-side writer.
//   - Stream state encoding for buf_cmd_writer.
//   - Helpers to build a command word and to classify MISC codes.
// ---------------------------------------------------------------------------
package buf_cmd_pkg;

    localparam int CMD_W = 40;

    localparam logic [1:0] OP_WRITE_REG = 2'b01;
    localparam logic [1:0] OP_MISC      = 2'b10;

    localparam logic [5:0] MISC_NOP               = 6'd0;
    localparam logic [5:0] MISC_STB               = 6'd1;
    localparam logic [5:0] MISC_WAIT_ALL          = 6'd2;
    localparam logic [5:0] MISC_WAIT_ANY          = 6'd3;
    localparam logic [5:0] MISC_CLEAR             = 6'd4;
    localparam logic [5:0] MISC_WAIT_FIFO         = 6'd5;
    localparam logic [5:0] MISC_PARAM_ADDR        = 6'd6;
    localparam logic [5:0] MISC_PARAM_WRITE_HI    = 6'd7;
    localparam logic [5:0] MISC_PARAM_WRITE_LO    = 6'd8;
    localparam logic [5:0] MISC_PARAM_WRITE_LO_NC = 6'd15;
    localparam logic [5:0] MISC_DONE              = 6'd63;

    // Upper byte of the DONE word; used to recognise it at accept and at pop.
    localparam logic [7:0] DONE_HDR = {OP_MISC, MISC_DONE};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_CLOSING = 2'd2
    } stream_state_e;

    // Host address bit 6 selects MISC; the low six bits are the reg/code field.
    function automatic logic [CMD_W-1:0] encodeCmd(input logic [6:0]  addr,
                                                   input logic [31:0] data);
        return {(addr[6] ? OP_MISC : OP_WRITE_REG), addr[5:0], data};
    endfunction

    // Legal MISC codes are the contiguous block 0..15 plus DONE.
    function automatic logic miscCodeOk(input logic [5:0] code);
        return (code <= MISC_PARAM_WRITE_LO_NC) || (code == MISC_DONE);
    endfunction

endpackage

// File: rtl/buf_cmd_skidq.sv
// ---------------------------------------------------------------------------
// buf_cmd_skidq
// QDEPTH x CMD_W circular queue. The caller guarantees push only when not
// full and pop only when not empty; the queue does no protection itself.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push_i       write wdata_i at the tail this cycle
//   pop_i        advance the head this cycle
//   wdata_i      word to store
//   rdata_o      current head word (storage is cleared by reset, so 0 after rst)
//   level_o      number of entries held
// ---------------------------------------------------------------------------
module buf_cmd_skidq
    import buf_cmd_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int LW     = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CMD_W-1:0] wdata_i,
    output logic [CMD_W-1:0] rdata_o,
    output logic [LW-1:0]    level_o
);

    localparam int PW = $clog2(QDEPTH);

    logic [CMD_W-1:0] mem_q [QDEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [LW-1:0]    level_q;

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= wdata_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    assign rdata_o = mem_q[head_q];
    assign level_o = level_q;

endmodule

// File: rtl/buf_cmd_writer.sv
// ---------------------------------------------------------------------------
// buf_cmd_writer
// Host-side encoder and pusher for the 40-bit command buffer stream. Host
// register writes become {op, code, data} words, are held in a small skid
// queue and pushed into the command FIFO. Tracks stream open/close around
// DONE and keeps push statistics and error flags.
// Optional feature macro: BUF_CMD_WRITER_CHECK_EN (reject illegal MISC codes).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   host_addr/data  [6]=0 WRITE_REG reg=[5:0], [6]=1 MISC code=[5:0]; payload
//   host_stb        one-cycle write strobe
//   host_busy       registered, queue full: next strobe is dropped
//   clear           clears words_pushed, overflow, bad_cmd (events win)
//   fifo_full       command FIFO backpressure
//   fifo_write      combinational push strobe; fifo_wdata = queue head
//   stream_active   stream open (first word accepted, DONE not yet pushed)
//   done_pushed     1-cycle pulse after the DONE word enters the FIFO
//   overflow        sticky: strobe dropped on full queue
//   bad_cmd         sticky: rejected MISC code (0 unless the macro is defined)
//   queue_level     entries held in the queue
//   words_pushed    saturating count of FIFO writes
// ---------------------------------------------------------------------------
module buf_cmd_writer
    import buf_cmd_pkg::*;
#(
    parameter  int QDEPTH = 2,
    parameter  int CNT_W  = 32,
    localparam int LW     = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       host_addr,
    input  logic [31:0]      host_data,
    input  logic             host_stb,
    output logic             host_busy,
    input  logic             clear,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [CMD_W-1:0] fifo_wdata,
    output logic             stream_active,
    output logic             done_pushed,
    output logic             overflow,
    output logic             bad_cmd,
    output logic [LW-1:0]    queue_level,
    output logic [CNT_W-1:0] words_pushed
);

    logic [CMD_W-1:0] cmdWord;
    logic             codeOk;
    logic             hasRoom;
    logic             accept;
    logic             dropFull;
    logic             pop;
    logic             acceptDone;
    logic             popDone;
    logic [LW-1:0]    nextLevel_d;
    stream_state_e    afterDone_d;

    stream_state_e    state_q;
    logic             hostBusy_q;
    logic             donePushed_q;
    logic             overflow_q;
    logic [CNT_W-1:0] wordsPushed_q;

    assign cmdWord = encodeCmd(host_addr, host_data);

`ifdef BUF_CMD_WRITER_CHECK_EN
    assign codeOk = !host_addr[6] || miscCodeOk(host_addr[5:0]);
`else
    assign codeOk = 1'b1;
`endif

    // Room is judged on the current level, so a same-cycle pop never frees a slot.
    // A rejected code consumes the strobe, so it can never count as a drop.
    assign hasRoom  = queue_level < LW'(QDEPTH);
    assign accept   = host_stb && codeOk && hasRoom;
    assign dropFull = host_stb && codeOk && !hasRoom;
    assign pop      = (queue_level != '0) && !fifo_full;

    assign acceptDone  = accept && (cmdWord[CMD_W-1:CMD_W-8] == DONE_HDR);
    assign popDone     = pop && (fifo_wdata[CMD_W-1:CMD_W-8] == DONE_HDR);
    assign nextLevel_d = queue_level + LW'(accept) - LW'(pop);

    buf_cmd_skidq #(
        .QDEPTH (QDEPTH)
    ) u_skidq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (cmdWord),
        .rdata_o (fifo_wdata),
        .level_o (queue_level)
    );

    // State once a DONE word leaves the queue: words queued behind it (or
    // arriving this cycle) immediately open the next stream.
    always_comb begin
        afterDone_d = S_IDLE;
        if (acceptDone) begin
            afterDone_d = S_CLOSING;
        end else if (accept || (queue_level > LW'(1))) begin
            afterDone_d = S_STREAM;
        end
    end

    // Stream FSM with its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hostBusy_q   <= 1'b0;
            donePushed_q <= 1'b0;
        end else begin
            hostBusy_q   <= (nextLevel_d == LW'(QDEPTH));
            donePushed_q <= popDone;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= acceptDone ? S_CLOSING : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (popDone) begin
                        state_q <= afterDone_d;
                    end else if (acceptDone) begin
                        state_q <= S_CLOSING;
                    end
                end
                S_CLOSING: begin
                    if (popDone) begin
                        state_q <= afterDone_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Statistics: clear loses against an event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wordsPushed_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (clear) begin
                wordsPushed_q <= CNT_W'(pop);
            end else if (pop && !(&wordsPushed_q)) begin
                wordsPushed_q <= wordsPushed_q + CNT_W'(1);
            end
            if (dropFull) begin
                overflow_q <= 1'b1;
            end else if (clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef BUF_CMD_WRITER_CHECK_EN
    logic badCmd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            badCmd_q <= 1'b0;
        end else if (host_stb && !codeOk) begin
            badCmd_q <= 1'b1;
        end else if (clear) begin
            badCmd_q <= 1'b0;
        end
    end

    assign bad_cmd = badCmd_q;
`else
    assign bad_cmd = 1'b0;
`endif

    assign fifo_write    = pop;
    assign host_busy     = hostBusy_q;
    assign done_pushed   = donePushed_q;
    assign overflow      = overflow_q;
    assign words_pushed  = wordsPushed_q;
    assign stream_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_buf_cmd_writer.sv
// ---------------------------------------------------------------------------
// tb_buf_cmd_writer
// Directed bench for buf_cmd_writer: an encoding table applied in a loop,
// then hand-written sequences for backpressure, DONE handling, same-cycle
// push/pop at full, clear priority, counter saturation and mid-run reset.
// ---------------------------------------------------------------------------
module tb_buf_cmd_writer;

    localparam int QDEPTH = 2;
    localparam int CNT_W  = 4;
    localparam int LW     = $clog2(QDEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       host_addr;
    logic [31:0]      host_data;
    logic             host_stb;
    logic             host_busy;
    logic             clear;
    logic             fifo_full;
    logic             fifo_write;
    logic [39:0]      fifo_wdata;
    logic             stream_active;
    logic             done_pushed;
    logic             overflow;
    logic             bad_cmd;
    logic [LW-1:0]    queue_level;
    logic [CNT_W-1:0] words_pushed;

    int testsRun    = 0;
    int testsFailed = 0;
    int expCount    = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        expWrite;
        logic [39:0] expWdata;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    buf_cmd_writer #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_stb      (host_stb),
        .host_busy     (host_busy),
        .clear         (clear),
        .fifo_full     (fifo_full),
        .fifo_write    (fifo_write),
        .fifo_wdata    (fifo_wdata),
        .stream_active (stream_active),
        .done_pushed   (done_pushed),
        .overflow      (overflow),
        .bad_cmd       (bad_cmd),
        .queue_level   (queue_level),
        .words_pushed  (words_pushed)
    );

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle host strobe; returns 1 ns after the edge that captured it.
    task automatic applyStimulus(input logic [6:0] addr, input logic [31:0] data);
        stepCycle();
        host_addr = addr;
        host_data = data;
        host_stb  = 1'b1;
        stepCycle();
        host_stb  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{7'h05, 32'h0000_1234, 1'b1, 40'h45_0000_1234};
        vecs[1] = '{7'h00, 32'hFFFF_FFFF, 1'b1, 40'h40_FFFF_FFFF};
        vecs[2] = '{7'h3F, 32'hDEAD_BEEF, 1'b1, 40'h7F_DEAD_BEEF};
        vecs[3] = '{7'h40, 32'h0000_0000, 1'b1, 40'h80_0000_0000};
`ifdef BUF_CMD_WRITER_CHECK_EN
        vecs[4] = '{7'h50, 32'hA5A5_A5A5, 1'b0, 40'h90_A5A5_A5A5};
`else
        vecs[4] = '{7'h50, 32'hA5A5_A5A5, 1'b1, 40'h90_A5A5_A5A5};
`endif
        vecs[5] = '{7'h48, 32'h0000_0001, 1'b1, 40'h88_0000_0001};

        rst       = 1'b1;
        host_addr = '0;
        host_data = '0;
        host_stb  = 1'b0;
        clear     = 1'b0;
        fifo_full = 1'b0;
        repeat (3) stepCycle();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_level",  64'(queue_level),   64'd0);
        checkOutput("rst_busy",   64'(host_busy),     64'd0);
        checkOutput("rst_write",  64'(fifo_write),    64'd0);
        checkOutput("rst_wdata",  64'(fifo_wdata),    64'd0);
        checkOutput("rst_active", 64'(stream_active), 64'd0);
        checkOutput("rst_done",   64'(done_pushed),   64'd0);
        checkOutput("rst_ovf",    64'(overflow),      64'd0);
        checkOutput("rst_bad",    64'(bad_cmd),       64'd0);
        checkOutput("rst_count",  64'(words_pushed),  64'd0);

        // Encoding table, FIFO ready: write appears the cycle after the strobe
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d_write", i), 64'(fifo_write), 64'(vecs[i].expWrite));
            if (vecs[i].expWrite) begin
                checkOutput($sformatf("vec%0d_wdata", i), 64'(fifo_wdata), 64'(vecs[i].expWdata));
                expCount++;
            end
            checkOutput($sformatf("vec%0d_active", i), 64'(stream_active), 64'd1);
            stepCycle();
            checkOutput($sformatf("vec%0d_level", i), 64'(queue_level), 64'd0);
            checkOutput($sformatf("vec%0d_count", i), 64'(words_pushed), 64'(expCount));
        end
`ifdef BUF_CMD_WRITER_CHECK_EN
        checkOutput("table_bad", 64'(bad_cmd), 64'd1);
`else
        checkOutput("table_bad", 64'(bad_cmd), 64'd0);
`endif

        // DONE closes the stream one cycle after it is pushed
        applyStimulus(7'h7F, 32'hCAFE_F00D);
        checkOutput("done_write",  64'(fifo_write),    64'd1);
        checkOutput("done_wdata",  64'(fifo_wdata),    64'hBF_CAFE_F00D);
        checkOutput("done_open",   64'(stream_active), 64'd1);
        stepCycle();
        expCount++;
        checkOutput("done_pulse",  64'(done_pushed),   64'd1);
        checkOutput("done_closed", 64'(stream_active), 64'd0);
        checkOutput("done_count",  64'(words_pushed),  64'(expCount));
        stepCycle();
        checkOutput("done_pulse_end", 64'(done_pushed), 64'd0);

        // Backpressure: two queued, third dropped, then drained in order
        fifo_full = 1'b1;
        stepCycle();
        host_stb  = 1'b1;
        host_addr = 7'h0A;
        host_data = 32'h0000_00AA;
        stepCycle();
        host_addr = 7'h0B;
        host_data = 32'h0000_00BB;
        stepCycle();
        host_addr = 7'h0C;
        host_data = 32'h0000_00CC;
        checkOutput("bp_busy_before", 64'(host_busy), 64'd1);
        stepCycle();
        host_stb = 1'b0;
        checkOutput("bp_level",  64'(queue_level),   64'd2);
        checkOutput("bp_ovf",    64'(overflow),      64'd1);
        checkOutput("bp_busy",   64'(host_busy),     64'd1);
        checkOutput("bp_nowr",   64'(fifo_write),    64'd0);
        checkOutput("bp_active", 64'(stream_active), 64'd1);
        fifo_full = 1'b0;
        #1;
        checkOutput("bp_w0",     64'(fifo_write), 64'd1);
        checkOutput("bp_w0data", 64'(fifo_wdata), 64'h4A_0000_00AA);
        stepCycle();
        checkOutput("bp_w1",     64'(fifo_write), 64'd1);
        checkOutput("bp_w1data", 64'(fifo_wdata), 64'h4B_0000_00BB);
        stepCycle();
        expCount += 2;
        checkOutput("bp_drained", 64'(fifo_write),   64'd0);
        checkOutput("bp_count",   64'(words_pushed), 64'(expCount));

        // clear alone
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        checkOutput("clr_ovf",   64'(overflow),     64'd0);
        checkOutput("clr_count", 64'(words_pushed), 64'd0);

        // Strobe + pop at full, with clear in the same cycle
        fifo_full = 1'b1;
        host_stb  = 1'b1;
        host_addr = 7'h01;
        host_data = 32'h0000_0011;
        stepCycle();
        host_addr = 7'h02;
        host_data = 32'h0000_0022;
        stepCycle();
        host_addr = 7'h03;
        host_data = 32'h0000_0033;
        fifo_full = 1'b0;
        clear     = 1'b1;
        #1;
        checkOutput("full_pop_write", 64'(fifo_write), 64'd1);
        checkOutput("full_pop_wdata", 64'(fifo_wdata), 64'h41_0000_0011);
        stepCycle();
        host_stb = 1'b0;
        clear    = 1'b0;
        checkOutput("full_pop_level", 64'(queue_level),  64'd1);
        checkOutput("full_pop_ovf",   64'(overflow),     64'd1);
        checkOutput("full_pop_count", 64'(words_pushed), 64'd1);
        checkOutput("full_pop_busy",  64'(host_busy),    64'd0);
        checkOutput("full_pop_next",  64'(fifo_wdata),   64'h42_0000_0022);
        stepCycle();
        checkOutput("full_pop_empty", 64'(queue_level),  64'd0);
        checkOutput("full_pop_cnt2",  64'(words_pushed), 64'd2);

        // Counter saturation: 17 back-to-back words into a 4-bit counter
        clear = 1'b1;
        stepCycle();
        clear    = 1'b0;
        host_stb = 1'b1;
        for (int i = 0; i < 17; i++) begin
            host_addr = 7'h10;
            host_data = 32'(i);
            stepCycle();
        end
        host_stb = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("sat_count", 64'(words_pushed), 64'hF);
        checkOutput("sat_level", 64'(queue_level),  64'd0);
        checkOutput("sat_ovf",   64'(overflow),     64'd0);

        // Reset with two words stuck behind a full FIFO
        fifo_full = 1'b1;
        applyStimulus(7'h21, 32'h0000_0021);
        applyStimulus(7'h22, 32'h0000_0022);
        checkOutput("mrst_pre_level", 64'(queue_level), 64'd2);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("mrst_level",  64'(queue_level),   64'd0);
        checkOutput("mrst_busy",   64'(host_busy),     64'd0);
        checkOutput("mrst_active", 64'(stream_active), 64'd0);
        checkOutput("mrst_count",  64'(words_pushed),  64'd0);
        fifo_full = 1'b0;
        #1;
        checkOutput("mrst_nowr0", 64'(fifo_write), 64'd0);
        stepCycle();
        checkOutput("mrst_nowr1", 64'(fifo_write),   64'd0);
        checkOutput("mrst_cnt1",  64'(words_pushed), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
